// File: rtl/register_init_pipe.sv
// DEPTH-stage, WIDTH-bit pipeline register with per-stage valid tags, an INIT idle value,
// clock enable, flush and a live count of valid stages.
module register_init_pipe #(
  parameter int               WIDTH = 16,
  parameter int               DEPTH = 4,
  parameter logic [WIDTH-1:0] INIT  = 16'b1111111011011100,
  localparam int              FW    = $clog2(DEPTH + 1)
) (
  input  logic             C,
  input  logic             R,
  input  logic             CE,
  input  logic [WIDTH-1:0] D,
  input  logic             DV,
  input  logic             FLUSH,
  output logic [WIDTH-1:0] Q,
  output logic             QV,
  output logic [FW-1:0]    FILL
);

  // Declaration initialisers give the power-up state without needing a reset pulse.
  logic [DEPTH-1:0][WIDTH-1:0] data_q = {DEPTH{INIT}};
  logic [DEPTH-1:0][WIDTH-1:0] data_d;
  logic [DEPTH-1:0]            vld_q  = '0;
  logic [DEPTH-1:0]            vld_d;
  logic [FW-1:0]               fill_q = '0;
  logic [FW-1:0]               fill_d;

  // Reset is handled in the register process; this block covers FLUSH > CE > hold.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
    data_d = data_q;
    vld_d  = vld_q;
    fill_d = fill_q;
    if (FLUSH) begin
      vld_d  = '0;
      fill_d = '0;
      if (CE) begin
        data_d[0] = D;
        for (int i = 1; i < DEPTH; i++) data_d[i] = data_q[i-1];
      end
    end else if (CE) begin
      data_d[0] = D;
      vld_d[0]  = DV;
      for (int i = 1; i < DEPTH; i++) begin
        data_d[i] = data_q[i-1];
        vld_d[i]  = vld_q[i-1];
      end
      // Entry and exit in the same cycle cancel out, so the count stays within 0..DEPTH.
      case ({DV, vld_q[DEPTH-1]})
        2'b10:   fill_d = fill_q + FW'(1);
        2'b01:   fill_d = fill_q - FW'(1);
        default: fill_d = fill_q;
      endcase
    end
  end

  always_ff @(posedge C) begin
    // NOTE: the data stages are discrete flops, not RAM, so resetting every one of them to INIT is legitimate.
    if (R) begin
      data_q <= {DEPTH{INIT}};
      vld_q  <= '0;
      fill_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every stage samples its pre-edge neighbour.
      data_q <= data_d;
      vld_q  <= vld_d;
      fill_q <= fill_d;
    end
  end

  assign Q    = data_q[DEPTH-1];
  assign QV   = vld_q[DEPTH-1];
  assign FILL = fill_q;

endmodule

// File: tb/tb_register_init_pipe.sv
// Directed bench for register_init_pipe (WIDTH=16, DEPTH=4) with hand-computed expectations
// and a per-cycle cross-check of Q/QV/FILL against a small behavioural model.
module tb_register_init_pipe;

  localparam int          WIDTH = 16;
  localparam int          DEPTH = 4;
  localparam logic [15:0] INIT  = 16'hFEDC;

  logic        C = 1'b0;
  logic        R = 1'b0;
  logic        CE = 1'b0;
  logic [15:0] D = '0;
  logic        DV = 1'b0;
  logic        FLUSH = 1'b0;
  logic [15:0] Q;
  logic        QV;
  logic [2:0]  FILL;

  int n_assert = 0;
  int n_fail   = 0;

  register_init_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .INIT(INIT)) dut (
    .C(C), .R(R), .CE(CE), .D(D), .DV(DV), .FLUSH(FLUSH),
    .Q(Q), .QV(QV), .FILL(FILL)
  );

  always #5 C = ~C;

  // Behavioural reference; FILL is compared against the popcount of its valid tags.
  logic [DEPTH-1:0][15:0] m_data = {DEPTH{INIT}};
  logic [DEPTH-1:0]       m_vld  = '0;

  always @(posedge C) begin
    if (R) begin
      m_data <= {DEPTH{INIT}};
      m_vld  <= '0;
    end else if (FLUSH) begin
      m_vld <= '0;
      if (CE) m_data <= {m_data[DEPTH-2:0], D};
    end else if (CE) begin
      m_data <= {m_data[DEPTH-2:0], D};
      m_vld  <= {m_vld[DEPTH-2:0], DV};
    end
  end

  always @(negedge C) begin
    n_assert++;
    assert (FILL === 3'($countones(m_vld))) else begin
      n_fail++;
      $error("FAIL model_fill t=%0t got %0d expected %0d", $time, FILL, $countones(m_vld));
    end
    n_assert++;
    assert (QV === m_vld[DEPTH-1] && Q === m_data[DEPTH-1]) else begin
      n_fail++;
      $error("FAIL model_q t=%0t got %h/%b expected %h/%b", $time, Q, QV,
             m_data[DEPTH-1], m_vld[DEPTH-1]);
    end
  end

  task automatic chk(input string tag, input logic [15:0] exp_q, input logic exp_qv,
                     input logic [2:0] exp_fill);
    n_assert++;
    assert (Q === exp_q) else begin
      n_fail++;
      $error("FAIL %s Q got %h expected %h", tag, Q, exp_q);
    end
    n_assert++;
    assert (QV === exp_qv) else begin
      n_fail++;
      $error("FAIL %s QV got %b expected %b", tag, QV, exp_qv);
    end
    n_assert++;
    assert (FILL === exp_fill) else begin
      n_fail++;
      $error("FAIL %s FILL got %0d expected %0d", tag, FILL, exp_fill);
    end
  endtask

  // Drive inputs, then let one rising edge pass and settle.
  task automatic step(input logic ce, input logic dv, input logic [15:0] d);
    CE = ce;
    DV = dv;
    D  = d;
    @(posedge C);
    #1;
  endtask

  initial begin
    logic [15:0] sq [11];
    logic        sv [11];
    logic [2:0]  sf [11];

    // Power-up state before any edge.
    #1;
    chk("powerup", INIT, 1'b0, 3'd0);

    // Continuous stream 1..5 then drain.
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, k <= 5, (k <= 5) ? 16'(k) : 16'd0);
      if (k >= 4)
        chk($sformatf("stream_k%0d", k), 16'(k - 3), 1'b1,
            (k <= 5) ? 3'd4 : 3'(9 - k));
      else
        chk($sformatf("stream_k%0d", k), INIT, 1'b0, 3'(k));
    end

    R = 1'b1;
    step(1'b0, 1'b0, 16'd0);
    R = 1'b0;
    chk("reset1", INIT, 1'b0, 3'd0);

    // Same stream with two CE-low cycles after word 3; those cycles present junk that must be ignored.
    sq = '{INIT, INIT, INIT, INIT, INIT, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd0};
    sv = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    sf = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    step(1'b1, 1'b1, 16'd1);  chk("stall_1",  sq[0],  sv[0],  sf[0]);
    step(1'b1, 1'b1, 16'd2);  chk("stall_2",  sq[1],  sv[1],  sf[1]);
    step(1'b1, 1'b1, 16'd3);  chk("stall_3",  sq[2],  sv[2],  sf[2]);
    step(1'b0, 1'b1, 16'd99); chk("stall_4",  sq[3],  sv[3],  sf[3]);
    step(1'b0, 1'b0, 16'd77); chk("stall_5",  sq[4],  sv[4],  sf[4]);
    step(1'b1, 1'b1, 16'd4);  chk("stall_6",  sq[5],  sv[5],  sf[5]);
    step(1'b1, 1'b1, 16'd5);  chk("stall_7",  sq[6],  sv[6],  sf[6]);
    for (int k = 7; k < 11; k++) begin
      step(1'b1, 1'b0, 16'd0);
      chk($sformatf("stall_%0d", k + 1), sq[k], sv[k], sf[k]);
    end

    // Fill, then flush with CE low: tags clear, data holds.
    for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 16'(20 + k));
    chk("full_before_flush", 16'd20, 1'b1, 3'd4);
    FLUSH = 1'b1;
    step(1'b0, 1'b1, 16'd88);
    FLUSH = 1'b0;
    chk("flush_ce0", 16'd20, 1'b0, 3'd0);
    step(1'b1, 1'b1, 16'd9);  chk("after_flush_1", 16'd21, 1'b0, 3'd1);
    step(1'b1, 1'b0, 16'd0);  chk("after_flush_2", 16'd22, 1'b0, 3'd1);
    step(1'b1, 1'b0, 16'd0);  chk("after_flush_3", 16'd23, 1'b0, 3'd1);
    step(1'b1, 1'b0, 16'd0);  chk("after_flush_4", 16'd9,  1'b1, 3'd1);
    step(1'b1, 1'b0, 16'd0);  chk("after_flush_5", 16'd0,  1'b0, 3'd0);

    // Reset beats flush/CE/DV while full; the presented word is dropped and every stage returns to INIT.
    for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 16'(30 + k));
    chk("full_before_reset", 16'd30, 1'b1, 3'd4);
    R = 1'b1;
    FLUSH = 1'b1;
    step(1'b1, 1'b1, 16'd55);
    R = 1'b0;
    FLUSH = 1'b0;
    chk("reset_prio", INIT, 1'b0, 3'd0);
    for (int k = 1; k <= 4; k++) begin
      step(1'b1, 1'b0, 16'd0);
      chk($sformatf("reset_drain_%0d", k), (k < 4) ? INIT : 16'd0, 1'b0, 3'd0);
    end

    // Alternating valid tags on D=10..17, then drain.
    for (int k = 1; k <= 12; k++) begin
      int j;
      int cnt;
      step(1'b1, (k <= 8) && (k % 2 == 1), (k <= 8) ? 16'(9 + k) : 16'd0);
      cnt = 0;
      for (int m = k - 3; m <= k; m++) if (m >= 1 && m <= 8 && (m % 2 == 1)) cnt++;
      j = k - 3;
      chk($sformatf("alt_k%0d", k), (j >= 1 && j <= 8) ? 16'(9 + j) : 16'd0,
          (j >= 1 && j <= 8 && (j % 2 == 1)), 3'(cnt));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
